// File: rtl/adder2b.sv
// ---------------------------------------------------------------------------
// adder2b : 2-bit ripple adder with registered result and carry statistics.
//
// The combinational sum {Cout,S} is built from a half adder on bit 0 and a
// full adder on bit 1. A registered copy of the result (sum_q), a
// "result valid since reset" flag, and a saturating count of carry edges
// are kept on the clock.
//
// Optional feature macro: ADDER2B_STICKY_CARRY_EN
//   defined   : carry_sticky latches 1 on the first non-reset edge with
//               Cout=1 and holds until reset.
//   undefined : carry_sticky is a constant 0 and no flop exists for it.
//
// Reset is synchronous and active-high. There is no asynchronous path, so
// the registered outputs are unknown until the first reset edge.
// ---------------------------------------------------------------------------
module adder2b (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [1:0] S,
    output logic       Cout,
    output logic [2:0] sum_q,
    output logic       valid_q,
    output logic [3:0] carry_cnt,
    output logic       carry_sticky
);

    // Half-adder sum / full-adder sum bit: parity of the inputs.
    function automatic logic f_xor3(input logic a, input logic b, input logic c);
        f_xor3 = a ^ b ^ c;
    endfunction

    // Carry of a full adder: majority of the three inputs.
    function automatic logic f_maj3(input logic a, input logic b, input logic c);
        f_maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    // Saturating increment; holds at all-ones instead of wrapping.
    function automatic logic [3:0] f_sat_inc(input logic [3:0] v);
        if (v == 4'hF) begin
            f_sat_inc = 4'hF;
        end else begin
            f_sat_inc = v + 4'd1;
        end
    endfunction

    logic       w_c0;
    logic [1:0] w_s;
    logic       w_cout;

    logic [2:0] r_sum_q;
    logic       r_valid_q;
    logic [3:0] r_carry_cnt;

    // Ripple adder: bit 0 half adder feeding the bit 1 full adder.
    always_comb begin
        w_c0   = A[0] & B[0];
        w_s    = 2'b00;
        w_s[0] = f_xor3(A[0], B[0], 1'b0);
        w_s[1] = f_xor3(A[1], B[1], w_c0);
        w_cout = f_maj3(A[1], B[1], w_c0);
    end

    assign S    = w_s;
    assign Cout = w_cout;

    // Capture the current sum and mark the result valid; reset clears both.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sum_q   <= 3'b000;
            r_valid_q <= 1'b0;
        end else begin
            r_sum_q   <= {w_cout, w_s};
            r_valid_q <= 1'b1;
        end
    end

    // Count edges that see a carry out, saturating at 15; reset wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_carry_cnt <= 4'h0;
        end else if (w_cout) begin
            r_carry_cnt <= f_sat_inc(r_carry_cnt);
        end else begin
            r_carry_cnt <= r_carry_cnt;
        end
    end

    assign sum_q     = r_sum_q;
    assign valid_q   = r_valid_q;
    assign carry_cnt = r_carry_cnt;

`ifdef ADDER2B_STICKY_CARRY_EN
    logic r_carry_sticky;

    // Remember that any carry occurred since the last reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_carry_sticky <= 1'b0;
        end else if (w_cout) begin
            r_carry_sticky <= 1'b1;
        end else begin
            r_carry_sticky <= r_carry_sticky;
        end
    end

    assign carry_sticky = r_carry_sticky;
`else
    assign carry_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_adder2b.sv
// ---------------------------------------------------------------------------
// tb_adder2b : self-checking bench for adder2b.
// A plain-arithmetic reference model tracks the expected outputs; a compare
// process checks the DUT against it on every falling edge, and directed
// scenarios pin the model with hand-computed literal values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adder2b;

    logic       clock;
    logic       reset;
    logic [1:0] A;
    logic [1:0] B;
    logic [1:0] S;
    logic       Cout;
    logic [2:0] sum_q;
    logic       valid_q;
    logic [3:0] carry_cnt;
    logic       carry_sticky;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_known = 1'b0;
    int         m_sum   = 0;
    logic       m_valid = 1'b0;
    int         m_cnt   = 0;
    logic       m_sticky = 1'b0;

    adder2b dut (
        .clock        (clock),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .S            (S),
        .Cout         (Cout),
        .sum_q        (sum_q),
        .valid_q      (valid_q),
        .carry_cnt    (carry_cnt),
        .carry_sticky (carry_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on each rising edge.
    always @(posedge clock) begin
        int total;
        total = int'(A) + int'(B);
        if (reset === 1'b1) begin
            m_known  <= 1'b1;
            m_sum    <= 0;
            m_valid  <= 1'b0;
            m_cnt    <= 0;
            m_sticky <= 1'b0;
        end else begin
            m_sum   <= total;
            m_valid <= 1'b1;
            if (total >= 4) begin
                m_cnt <= (m_cnt >= 15) ? 15 : m_cnt + 1;
`ifdef ADDER2B_STICKY_CARRY_EN
                m_sticky <= 1'b1;
`endif
            end
        end
    end

    // Compare process: every falling edge.
    always @(negedge clock) begin
        int total;
        total = int'(A) + int'(B);
        check("comb_sum", {29'd0, Cout, S}, total);
        if (m_known) begin
            check("sum_q", int'(sum_q), m_sum);
            check("valid_q", int'(valid_q), int'(m_valid));
            check("carry_cnt", int'(carry_cnt), m_cnt);
            check("carry_sticky", int'(carry_sticky), int'(m_sticky));
        end
    end

    initial begin
        int sticky_exp;
`ifdef ADDER2B_STICKY_CARRY_EN
        sticky_exp = 1;
`else
        sticky_exp = 0;
`endif
        reset = 1'b1;
        A = 2'd0;
        B = 2'd0;

        // Reset state
        @(posedge clock); @(posedge clock); #1;
        check("rst_sum_q", int'(sum_q), 0);
        check("rst_valid_q", int'(valid_q), 0);
        check("rst_carry_cnt", int'(carry_cnt), 0);
        check("rst_sticky", int'(carry_sticky), 0);
        #1 reset = 1'b0;

        // Exhaustive sweep, one vector per 10-unit step
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                A = 2'(a);
                B = 2'(b);
                #1;
                if (a == 1 && b == 2) begin
                    check("lit_1p2_S", int'(S), 3);
                    check("lit_1p2_Cout", int'(Cout), 0);
                end
                if (a == 2 && b == 3) begin
                    check("lit_2p3_S", int'(S), 1);
                    check("lit_2p3_Cout", int'(Cout), 1);
                end
                @(posedge clock); #2;
            end
        end
        // six sweep pairs carry out: 1+3, 2+2, 2+3, 3+1, 3+2, 3+3
        #1 check("lit_sweep_cnt", int'(carry_cnt), 6);

        // Max case 3+3 from a clean reset
        @(posedge clock); #2 reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        A = 2'd3; B = 2'd3;
        #1;
        check("lit_3p3_S", int'(S), 2);
        check("lit_3p3_Cout", int'(Cout), 1);
        @(posedge clock); #1;
        check("lit_3p3_sum_q", int'(sum_q), 6);
        check("lit_3p3_cnt", int'(carry_cnt), 1);

        // Saturation: reset while carrying, then hold 2+2 for 20 edges
        #1 reset = 1'b1; A = 2'd2; B = 2'd2;
        @(posedge clock); #1;
        check("lit_rst_prio_cnt", int'(carry_cnt), 0);
        #1 reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (k == 14) check("lit_sat_14", int'(carry_cnt), 14);
            if (k == 15) check("lit_sat_15", int'(carry_cnt), 15);
            if (k == 20) check("lit_sat_20", int'(carry_cnt), 15);
        end
        check("lit_sticky_after_sat", int'(carry_sticky), sticky_exp);

        // Mid-operation reset with 3+1
        #1 reset = 1'b1; A = 2'd3; B = 2'd1;
        #1;
        check("lit_3p1_S", int'(S), 0);
        check("lit_3p1_Cout", int'(Cout), 1);
        @(posedge clock); #1;
        check("lit_mid_rst_sum_q", int'(sum_q), 0);
        check("lit_mid_rst_valid", int'(valid_q), 0);
        check("lit_mid_rst_cnt", int'(carry_cnt), 0);
        check("lit_mid_rst_sticky", int'(carry_sticky), 0);
        check("lit_mid_rst_Cout", int'(Cout), 1);

        // Release reset with 1+0
        #1 reset = 1'b0; A = 2'd1; B = 2'd0;
        @(posedge clock); #1;
        check("lit_rel_valid", int'(valid_q), 1);
        check("lit_rel_sum_q", int'(sum_q), 1);
        check("lit_rel_cnt", int'(carry_cnt), 0);

        // Inputs changing between edges: only the edge-time value is captured
        #1 A = 2'd3; B = 2'd2;
        #5 A = 2'd0; B = 2'd1;
        @(posedge clock); #1;
        check("lit_between_sum_q", int'(sum_q), 1);
        check("lit_between_cnt", int'(carry_cnt), 0);
        #1 A = 2'd1; B = 2'd1;
        #5 A = 2'd2; B = 2'd3;
        @(posedge clock); #1;
        check("lit_between2_sum_q", int'(sum_q), 5);
        check("lit_between2_cnt", int'(carry_cnt), 1);

        @(posedge clock); @(posedge clock); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder2b.md
ADDER2B -- requirements
Module: adder2b

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, and no parameters.
REQ-002 Port list (name  direction  width  meaning):
- clock  input  1  sole clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- A  input  2  unsigned addend.
- B  input  2  unsigned addend.
- S  output  2  combinational sum bits, A+B modulo 4.
- Cout  output  1  combinational carry out of bit 1.
- sum_q  output  3  registered {Cout,S}.
- valid_q  output  1  sum_q holds a sum captured since reset.
- carry_cnt  output  4  saturating count of clock edges with Cout=1.
- carry_sticky  output  1  latched "a carry has occurred" flag (see Configuration).

Function
REQ-003 S and Cout SHALL be purely combinational from A and B, with {Cout,S} = A + B as a 3-bit unsigned result and zero clock latency.
REQ-004 The adder SHALL be a 2-stage ripple structure: bit 0 is a half adder (S[0]=A[0]^B[0], c0=A[0]&B[0]); bit 1 is a full adder fed by c0 (S[1]=A[1]^B[1]^c0, Cout=majority(A[1],B[1],c0)).
REQ-005 Value range: 0..6 on {Cout,S}; the maximum case 3+3 SHALL give S=2'b10 and Cout=1.
REQ-006 The S and Cout outputs SHALL not depend on clock or reset.
REQ-007 On each rising clock edge with reset=0, sum_q SHALL load {Cout,S}, giving one-cycle latency from the inputs.
REQ-008 On each rising clock edge with reset=0, valid_q SHALL become 1 and stay at 1 until the next reset.
REQ-009 On each rising clock edge with reset=0 and Cout=1, carry_cnt SHALL increment by 1 and saturate at 4'hF (no wrap).
REQ-010 On an edge with Cout=0, carry_cnt SHALL hold.
REQ-011 Inputs that change between edges SHALL affect only the combinational outputs until the next edge.

Reset
REQ-012 While reset=1 at a rising edge, the following SHALL be forced: sum_q=3'b000, valid_q=0, carry_cnt=4'h0, carry_sticky=0.
REQ-013 Reset SHALL take priority over all updates on the same edge, including an edge where Cout=1.
REQ-014 Reset asserted mid-operation SHALL clear the registered state on the next edge without disturbing S and Cout.
REQ-015 Registered outputs are undefined before the first reset edge; no asynchronous reset path SHALL exist.

Configuration
REQ-016 Macro ADDER2B_STICKY_CARRY_EN SHALL control the carry_sticky output.
REQ-017 With the macro defined, carry_sticky SHALL set to 1 on any non-reset edge where Cout=1 and hold until reset.
REQ-018 Without the macro, carry_sticky SHALL be tied to constant 0, with no flop inferred.
REQ-019 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-020 Exhaustive sweep of A and B over 0..3 (16 cases), 10-time-unit steps: {Cout,S} SHALL equal A+B for every case, e.g. 1+2 gives S=11, Cout=0, and 2+3 gives S=01, Cout=1.
REQ-021 Apply A=3, B=3, then one edge: S=10 and Cout=1 immediately; sum_q=3'b110 and carry_cnt=1 after the edge.
REQ-022 Hold A=2, B=2 for 20 edges: carry_cnt SHALL read 4'hF from the 15th edge onward; with the macro defined, carry_sticky SHALL be 1.
REQ-023 Assert reset on an edge while A=3, B=1: sum_q=0, valid_q=0, carry_cnt=0 and carry_sticky=0, while S=00 and Cout=1 combinationally.
REQ-024 Release reset with A=1, B=0: valid_q=1 and sum_q=3'b001 after one edge; carry_cnt is unchanged at 0.
